uart_tx_msg_frm: RTL and testbench

Parametrised successor to the fixed-format message UART transmitter. Serialises a variable-length message of up to MAX_LEN words onto one UART line. Data width, parity mode and stop-bit count are set per instance. Sits between command/telemetry formatters and the board TX pin, with the same block/send/busy handshake as the existing transmitter.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_msg_frm_if.sv | 33 +++
 rtl/uart_baud_ctr.sv | 26 ++
 rtl/uart_tx_msg_frm.sv | 159 +++++++++++++++
 tb/tb_uart_tx_msg_frm.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter state encoding and a
// helper for deriving CLK_PER_BIT from a clock frequency and baud rate.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  // Rounded clock-cycles-per-bit, e.g. baud_div(50_000_000, 115200) = 434.
  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_msg_frm_if.sv
// Message-level handshake between a formatter (master) and the UART message
// transmitter (slave). With UART_TX_MSG_FRM_ABORT_EN defined the bundle also
// carries the abort request and the sticky aborted status.
interface uart_tx_msg_frm_if #(
  parameter int MAX_LEN   = 64,
  parameter int DATA_BITS = 8
);
  localparam int LW = $clog2(MAX_LEN + 1);

  logic                         block;
  logic                         send;
  logic [LW-1:0]                len;
  logic [DATA_BITS*MAX_LEN-1:0] msg;
  logic                         busy;
  logic                         done;
  logic                         tx;

`ifdef UART_TX_MSG_FRM_ABORT_EN
  logic abort;
  logic aborted;

  modport master (output block, send, len, msg, abort,
                  input  busy, done, tx, aborted);
  modport slave  (input  block, send, len, msg, abort,
                  output busy, done, tx, aborted);
`else
  modport master (output block, send, len, msg,
                  input  busy, done, tx);
  modport slave  (input  block, send, len, msg,
                  output busy, done, tx);
`endif

endinterface

// File: rtl/uart_baud_ctr.sv
// Bit-period counter: counts while enabled, restarts on clr, and raises tick
// on the last cycle of every CLK_PER_BIT-cycle period.
module uart_baud_ctr #(
  parameter int CLK_PER_BIT = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_PER_BIT - 1);

  logic [W-1:0] cnt;

  // Count 0..CLK_PER_BIT-1 while enabled; hold at 0 otherwise.
  always_ff @(posedge clk) begin
    if (rst || clr || !en) cnt <= '0;
    else if (cnt == LAST)  cnt <= '0;
    else                   cnt <= cnt + W'(1);
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/uart_tx_msg_frm.sv
// Variable-length message UART transmitter. Sends min(len, MAX_LEN) words of
// DATA_BITS each, LSB first, with optional parity and 1 or 2 stop bits, and no
// idle gap between words. Define UART_TX_MSG_FRM_ABORT_EN to add an abort
// request that finishes the current word and then ends the message early.
module uart_tx_msg_frm
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = 50,
  parameter int MAX_LEN     = 64,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input logic           clk,
  input logic           rst,
  uart_tx_msg_frm_if.slave bus
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam parity_e PAR = parity_e'(PARITY[1:0]);
  localparam logic [3:0] LAST_DBIT = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_SBIT = 4'(STOP_BITS - 1);

  state_e state, state_d;
  logic [3:0]    bit_cnt, bit_d;
  logic [LW-1:0] word_cnt, word_d, len_q;
  // Word 0 sits at the MSB end of msg, so an ascending array maps index n to word n.
  logic [0:MAX_LEN-1][DATA_BITS-1:0] msg_q;
  logic [DATA_BITS-1:0] cur_word, shifted;
  logic tx_q, tx_d, busy_q, busy_d, done_q, done_d;
  logic tick, accept, baud_en, par_bit, abort_pend;

  // A send landing on the done cycle is deliberately not taken.
  assign accept  = (state == ST_IDLE) && !bus.block && bus.send &&
                   (bus.len != '0) && !done_q;
  assign baud_en = (state != ST_IDLE);
  assign cur_word = msg_q[word_cnt[IW-1:0]];
  assign par_bit  = (PAR == PAR_ODD) ? ~(^cur_word) : ^cur_word;

  uart_baud_ctr #(.CLK_PER_BIT(CLK_PER_BIT)) u_baud (
    .clk  (clk),
    .rst  (rst),
    .en   (baud_en),
    .clr  (accept),
    .tick (tick)
  );

  // Next-state logic: advance one bit per baud tick, one word per frame.
  always_comb begin
    state_d = state;
    bit_d   = bit_cnt;
    word_d  = word_cnt;
    done_d  = 1'b0;
    case (state)
      ST_IDLE: if (accept) begin
        state_d = ST_START;
        bit_d   = '0;
        word_d  = '0;
      end
      ST_START: if (tick) begin
        state_d = ST_DATA;
        bit_d   = '0;
      end
      ST_DATA: if (tick) begin
        if (bit_cnt == LAST_DBIT) begin
          state_d = (PAR == PAR_NONE) ? ST_STOP : ST_PARITY;
          bit_d   = '0;
        end else begin
          bit_d = bit_cnt + 4'd1;
        end
      end
      ST_PARITY: if (tick) begin
        state_d = ST_STOP;
        bit_d   = '0;
      end
      ST_STOP: if (tick) begin
        if (bit_cnt == LAST_SBIT) begin
          bit_d = '0;
          if ((word_cnt == len_q - LW'(1)) || abort_pend) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_START;
            word_d  = word_cnt + LW'(1);
          end
        end else begin
          bit_d = bit_cnt + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line level and busy for the coming cycle, so tx and busy are registered.
  always_comb begin
    shifted = cur_word >> bit_d;
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shifted[0];
      ST_PARITY: tx_d = par_bit;
      default:   tx_d = 1'b1;
    endcase
    busy_d = (state_d != ST_IDLE) || ((state == ST_IDLE) && bus.block);
  end

  // State, counters, message capture and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      word_cnt <= '0;
      len_q    <= '0;
      msg_q    <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_d;
      bit_cnt  <= bit_d;
      word_cnt <= word_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      if (accept) begin
        len_q <= (bus.len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : bus.len;
        msg_q <= bus.msg;
      end
    end
  end

`ifdef UART_TX_MSG_FRM_ABORT_EN
  logic aborted_q;

  // Remember an abort until the current frame ends; aborted stays set until the next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      abort_pend <= 1'b0;
      aborted_q  <= 1'b0;
    end else if (accept) begin
      abort_pend <= 1'b0;
      aborted_q  <= 1'b0;
    end else if (done_d) begin
      abort_pend <= 1'b0;
      if (abort_pend) aborted_q <= 1'b1;
    end else if (bus.abort && (state != ST_IDLE)) begin
      abort_pend <= 1'b1;
    end
  end

  assign bus.aborted = aborted_q;
`else
  assign abort_pend = 1'b0;
`endif

  assign bus.tx   = tx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_uart_tx_msg_frm.sv
// Directed bench for uart_tx_msg_frm: three instances cover no-parity/1-stop,
// even-parity/2-stop and odd-parity/1-stop, all at 4 clocks per bit.
module tb_uart_tx_msg_frm;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_msg_frm_if #(.MAX_LEN(8), .DATA_BITS(8)) if0 ();
  uart_tx_msg_frm_if #(.MAX_LEN(2), .DATA_BITS(8)) ife ();
  uart_tx_msg_frm_if #(.MAX_LEN(2), .DATA_BITS(8)) ifo ();

  uart_tx_msg_frm #(.CLK_PER_BIT(CPB), .MAX_LEN(8), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
    u0 (.clk(clk), .rst(rst), .bus(if0));
  uart_tx_msg_frm #(.CLK_PER_BIT(CPB), .MAX_LEN(2), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2))
    ue (.clk(clk), .rst(rst), .bus(ife));
  uart_tx_msg_frm #(.CLK_PER_BIT(CPB), .MAX_LEN(2), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1))
    uo (.clk(clk), .rst(rst), .bus(ifo));

  int tests = 0;
  int fails = 0;
  logic txl [0:1023];
  logic bl  [0:1023];
  logic dl  [0:1023];
  logic exp_q [$];

  // Expected line levels, one entry per bit period.
  function automatic void push_frame(input logic [7:0] w, input int par, input int sb);
    logic p;
    p = ^w;
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(w[i]);
    if (par == 2) exp_q.push_back(p);
    else if (par == 1) exp_q.push_back(~p);
    for (int i = 0; i < sb; i++) exp_q.push_back(1'b1);
  endfunction

  // Record tx/busy/done of one instance for n cycles starting at index from.
  task automatic capture(input int d, input int from, input int n);
    for (int k = from; k < from + n; k++) begin
      case (d)
        0:       begin txl[k] = if0.tx; bl[k] = if0.busy; dl[k] = if0.done; end
        1:       begin txl[k] = ife.tx; bl[k] = ife.busy; dl[k] = ife.done; end
        default: begin txl[k] = ifo.tx; bl[k] = ifo.busy; dl[k] = ifo.done; end
      endcase
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    tests++; if (if0.tx !== 1'b1)   begin fails++; $display("FAIL rst_tx0 got %b exp 1", if0.tx); end
    tests++; if (if0.busy !== 1'b0) begin fails++; $display("FAIL rst_busy0 got %b exp 0", if0.busy); end
    tests++; if (if0.done !== 1'b0) begin fails++; $display("FAIL rst_done0 got %b exp 0", if0.done); end
    tests++; if (ife.tx !== 1'b1)   begin fails++; $display("FAIL rst_txe got %b exp 1", ife.tx); end
    tests++; if (ife.busy !== 1'b0) begin fails++; $display("FAIL rst_busye got %b exp 0", ife.busy); end
    tests++; if (ifo.tx !== 1'b1)   begin fails++; $display("FAIL rst_txo got %b exp 1", ifo.tx); end
    tests++; if (ifo.done !== 1'b0) begin fails++; $display("FAIL rst_doneo got %b exp 0", ifo.done); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int bsum, dsum;
    exp_q.delete();
    push_frame(8'h41, 0, 1);
    push_frame(8'h42, 0, 1);
    if0.msg = {8'h41, 8'h42, 48'h0};
    if0.len = 4'd2;
    if0.send = 1'b1;
    @(posedge clk); #1;
    if0.send = 1'b0;
    capture(0, 0, 83);
    for (int k = 0; k < 80; k++) begin
      tests++;
      if (txl[k] !== exp_q[k / CPB]) begin
        fails++; $display("FAIL basic_tx cyc %0d got %b exp %b", k, txl[k], exp_q[k / CPB]);
      end
    end
    bsum = 0; dsum = 0;
    for (int k = 0; k < 83; k++) begin bsum += int'(bl[k]); dsum += int'(dl[k]); end
    tests++; if (bsum != 80) begin fails++; $display("FAIL basic_busy_cycles got %0d exp 80", bsum); end
    tests++; if (dsum != 1)  begin fails++; $display("FAIL basic_done_count got %0d exp 1", dsum); end
    tests++; if (dl[80] !== 1'b1) begin fails++; $display("FAIL basic_done_pos got %b exp 1", dl[80]); end
    tests++; if (bl[80] !== 1'b0) begin fails++; $display("FAIL basic_busy_at_done got %b exp 0", bl[80]); end
  endtask

  task automatic test_parity();
    // even parity, 2 stop bits: 12 bit periods
    exp_q.delete();
    push_frame(8'h07, 2, 2);
    ife.msg = {8'h07, 8'h00};
    ife.len = 2'd1;
    ife.send = 1'b1;
    @(posedge clk); #1;
    ife.send = 1'b0;
    capture(1, 0, 50);
    for (int k = 0; k < 48; k++) begin
      tests++;
      if (txl[k] !== exp_q[k / CPB]) begin
        fails++; $display("FAIL even_tx cyc %0d got %b exp %b", k, txl[k], exp_q[k / CPB]);
      end
    end
    tests++; if (txl[9*CPB+1] !== 1'b1) begin fails++; $display("FAIL even_par_bit got %b exp 1", txl[9*CPB+1]); end
    for (int k = 40; k < 48; k++) begin
      tests++; if (txl[k] !== 1'b1) begin fails++; $display("FAIL even_stop cyc %0d got %b exp 1", k, txl[k]); end
    end
    tests++; if (dl[48] !== 1'b1) begin fails++; $display("FAIL even_done_pos got %b exp 1", dl[48]); end
    tests++; if (bl[47] !== 1'b1) begin fails++; $display("FAIL even_busy_last got %b exp 1", bl[47]); end

    // odd parity, 1 stop bit: 11 bit periods
    exp_q.delete();
    push_frame(8'h07, 1, 1);
    ifo.msg = {8'h07, 8'h00};
    ifo.len = 2'd1;
    ifo.send = 1'b1;
    @(posedge clk); #1;
    ifo.send = 1'b0;
    capture(2, 0, 46);
    for (int k = 0; k < 44; k++) begin
      tests++;
      if (txl[k] !== exp_q[k / CPB]) begin
        fails++; $display("FAIL odd_tx cyc %0d got %b exp %b", k, txl[k], exp_q[k / CPB]);
      end
    end
    tests++; if (txl[9*CPB+1] !== 1'b0) begin fails++; $display("FAIL odd_par_bit got %b exp 0", txl[9*CPB+1]); end
    tests++; if (dl[44] !== 1'b1) begin fails++; $display("FAIL odd_done_pos got %b exp 1", dl[44]); end
  endtask

  task automatic test_block();
    exp_q.delete();
    push_frame(8'h55, 0, 1);
    if0.msg = {8'h55, 56'h0};
    if0.len = 4'd1;
    if0.block = 1'b1;
    if0.send = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tests++; if (if0.busy !== 1'b1) begin fails++; $display("FAIL block_busy %0d got %b exp 1", i, if0.busy); end
      tests++; if (if0.tx !== 1'b1)   begin fails++; $display("FAIL block_tx %0d got %b exp 1", i, if0.tx); end
    end
    if0.block = 1'b0;
    @(posedge clk); #1;
    if0.send = 1'b0;
    capture(0, 0, 43);
    for (int k = 0; k < 40; k++) begin
      tests++;
      if (txl[k] !== exp_q[k / CPB]) begin
        fails++; $display("FAIL block_tx_frame cyc %0d got %b exp %b", k, txl[k], exp_q[k / CPB]);
      end
    end
    tests++; if (dl[40] !== 1'b1) begin fails++; $display("FAIL block_done_pos got %b exp 1", dl[40]); end
  endtask

  task automatic test_len_edges();
    int bsum, dsum, zsum;
    // len = 0 is ignored
    if0.len = 4'd0;
    if0.send = 1'b1;
    @(posedge clk); #1;
    if0.send = 1'b0;
    capture(0, 0, 20);
    bsum = 0; dsum = 0; zsum = 0;
    for (int k = 0; k < 20; k++) begin
      bsum += int'(bl[k]); dsum += int'(dl[k]); zsum += int'(!txl[k]);
    end
    tests++; if (bsum != 0) begin fails++; $display("FAIL len0_busy got %0d exp 0", bsum); end
    tests++; if (dsum != 0) begin fails++; $display("FAIL len0_done got %0d exp 0", dsum); end
    tests++; if (zsum != 0) begin fails++; $display("FAIL len0_tx_low got %0d exp 0", zsum); end

    // len = MAX_LEN+5 is clamped to MAX_LEN words
    exp_q.delete();
    for (int i = 0; i < 8; i++) push_frame(8'(8'h10 + i), 0, 1);
    if0.msg = 64'h1011121314151617;
    if0.len = 4'd13;
    if0.send = 1'b1;
    @(posedge clk); #1;
    if0.send = 1'b0;
    capture(0, 0, 323);
    for (int k = 0; k < 320; k++) begin
      tests++;
      if (txl[k] !== exp_q[k / CPB]) begin
        fails++; $display("FAIL maxlen_tx cyc %0d got %b exp %b", k, txl[k], exp_q[k / CPB]);
      end
    end
    bsum = 0;
    for (int k = 0; k < 323; k++) bsum += int'(bl[k]);
    tests++; if (bsum != 320) begin fails++; $display("FAIL maxlen_busy_cycles got %0d exp 320", bsum); end
    tests++; if (dl[320] !== 1'b1) begin fails++; $display("FAIL maxlen_done_pos got %b exp 1", dl[320]); end
  endtask

  task automatic test_reset_mid();
    if0.msg = {8'h41, 8'h42, 48'h0};
    if0.len = 4'd2;
    if0.send = 1'b1;
    @(posedge clk); #1;
    if0.send = 1'b0;
    capture(0, 0, 52);
    tests++; if (bl[51] !== 1'b1) begin fails++; $display("FAIL mid_busy_before got %b exp 1", bl[51]); end
    rst = 1'b1;
    @(posedge clk); #1;
    tests++; if (if0.tx !== 1'b1)   begin fails++; $display("FAIL mid_rst_tx got %b exp 1", if0.tx); end
    tests++; if (if0.busy !== 1'b0) begin fails++; $display("FAIL mid_rst_busy got %b exp 0", if0.busy); end
    tests++; if (if0.done !== 1'b0) begin fails++; $display("FAIL mid_rst_done got %b exp 0", if0.done); end
    rst = 1'b0;
    exp_q.delete();
    push_frame(8'hA5, 0, 1);
    if0.msg = {8'hA5, 8'hFF, 48'h0};
    if0.len = 4'd1;
    if0.send = 1'b1;
    @(posedge clk); #1;
    if0.send = 1'b0;
    capture(0, 0, 43);
    for (int k = 0; k < 40; k++) begin
      tests++;
      if (txl[k] !== exp_q[k / CPB]) begin
        fails++; $display("FAIL mid_resend_tx cyc %0d got %b exp %b", k, txl[k], exp_q[k / CPB]);
      end
    end
    tests++; if (dl[40] !== 1'b1) begin fails++; $display("FAIL mid_resend_done got %b exp 1", dl[40]); end
  endtask

  task automatic test_back_to_back();
    if0.msg = {8'h33, 56'h0};
    if0.len = 4'd1;
    if0.send = 1'b1;
    @(posedge clk); #1;
    capture(0, 0, 44);
    if0.send = 1'b0;
    tests++; if (dl[40] !== 1'b1)  begin fails++; $display("FAIL b2b_done got %b exp 1", dl[40]); end
    tests++; if (bl[40] !== 1'b0)  begin fails++; $display("FAIL b2b_busy_done got %b exp 0", bl[40]); end
    tests++; if (bl[41] !== 1'b0)  begin fails++; $display("FAIL b2b_busy_after got %b exp 0", bl[41]); end
    tests++; if (txl[41] !== 1'b1) begin fails++; $display("FAIL b2b_tx_after got %b exp 1", txl[41]); end
    tests++; if (bl[42] !== 1'b1)  begin fails++; $display("FAIL b2b_busy_restart got %b exp 1", bl[42]); end
    tests++; if (txl[42] !== 1'b0) begin fails++; $display("FAIL b2b_tx_restart got %b exp 0", txl[42]); end
    repeat (45) @(posedge clk);
    #1;
  endtask

`ifdef UART_TX_MSG_FRM_ABORT_EN
  task automatic test_abort();
    int dsum, bsum, zsum;
    exp_q.delete();
    push_frame(8'h41, 0, 1);
    if0.msg = {8'h41, 8'h42, 8'h43, 40'h0};
    if0.len = 4'd3;
    if0.send = 1'b1;
    @(posedge clk); #1;
    if0.send = 1'b0;
    capture(0, 0, 10);
    if0.abort = 1'b1;
    capture(0, 10, 1);
    if0.abort = 1'b0;
    capture(0, 11, 70);
    for (int k = 0; k < 40; k++) begin
      tests++;
      if (txl[k] !== exp_q[k / CPB]) begin
        fails++; $display("FAIL abort_tx cyc %0d got %b exp %b", k, txl[k], exp_q[k / CPB]);
      end
    end
    dsum = 0; bsum = 0; zsum = 0;
    for (int k = 0; k < 81; k++) begin bsum += int'(bl[k]); dsum += int'(dl[k]); end
    for (int k = 40; k < 81; k++) zsum += int'(!txl[k]);
    tests++; if (dl[40] !== 1'b1) begin fails++; $display("FAIL abort_done_pos got %b exp 1", dl[40]); end
    tests++; if (dsum != 1)  begin fails++; $display("FAIL abort_done_count got %0d exp 1", dsum); end
    tests++; if (bsum != 40) begin fails++; $display("FAIL abort_busy_cycles got %0d exp 40", bsum); end
    tests++; if (zsum != 0)  begin fails++; $display("FAIL abort_tail_tx_low got %0d exp 0", zsum); end
    tests++; if (if0.aborted !== 1'b1) begin fails++; $display("FAIL abort_flag got %b exp 1", if0.aborted); end
    if0.len = 4'd1;
    if0.send = 1'b1;
    @(posedge clk); #1;
    if0.send = 1'b0;
    tests++; if (if0.aborted !== 1'b0) begin fails++; $display("FAIL abort_flag_clear got %b exp 0", if0.aborted); end
    repeat (45) @(posedge clk);
    #1;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    if0.block = 1'b0; if0.send = 1'b0; if0.len = '0; if0.msg = '0;
    ife.block = 1'b0; ife.send = 1'b0; ife.len = '0; ife.msg = '0;
    ifo.block = 1'b0; ifo.send = 1'b0; ifo.len = '0; ifo.msg = '0;
`ifdef UART_TX_MSG_FRM_ABORT_EN
    if0.abort = 1'b0; ife.abort = 1'b0; ifo.abort = 1'b0;
`endif
    test_reset();
    test_basic();
    test_parity();
    test_block();
    test_len_edges();
    test_reset_mid();
    test_back_to_back();
`ifdef UART_TX_MSG_FRM_ABORT_EN
    test_abort();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
